// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with retired-instruction counter.
// Define CTRL_MEM_WAIT_EN to add a Mem_Ready input that stretches MEM until memory is ready.
module control_fsm #(
   parameter int COUNT_W = 32
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [31:0]        Instr,
   input  logic               ALU_Zero,
`ifdef CTRL_MEM_WAIT_EN
   input  logic               Mem_Ready,
`endif
   output logic               PC_sel,
   output logic               PC_LdEn,
   output logic               RF_WrEn,
   output logic               RF_WrData_sel,
   output logic               RF_B_sel,
   output logic               ALU_Bin_sel,
   output logic [3:0]         ALU_func,
   output logic               MEM_WrEn,
   output logic               ByteOp,
   output logic [2:0]         State,
   output logic [COUNT_W-1:0] Instr_Count
);
   localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4;
   logic [5:0] op;
   logic [2:0] next_state;
   logic is_r, is_addi, is_andi, is_ori, is_li, is_lui, is_b, is_beq, is_bne;
   logic is_lb, is_lw, is_sb, is_sw, is_br, is_ld, is_st, legal, mem_done;
   logic unused_bits;
   assign op          = Instr[31:26];
   assign unused_bits = ^Instr[25:4];
   assign is_r    = op == 6'b100000;
   assign is_addi = op == 6'b110000;
   assign is_andi = op == 6'b110010;
   assign is_ori  = op == 6'b110011;
   assign is_li   = op == 6'b111000;
   assign is_lui  = op == 6'b111001;
   assign is_b    = op == 6'b111111;
   assign is_beq  = op == 6'b000000;
   assign is_bne  = op == 6'b000001;
   assign is_lb   = op == 6'b000011;
   assign is_lw   = op == 6'b001111;
   assign is_sb   = op == 6'b000111;
   assign is_sw   = op == 6'b011111;
   assign is_br   = is_b | is_beq | is_bne;
   assign is_ld   = is_lb | is_lw;
   assign is_st   = is_sb | is_sw;
   assign legal   = is_r | is_addi | is_andi | is_ori | is_li | is_lui | is_br | is_ld | is_st;
`ifdef CTRL_MEM_WAIT_EN
   assign mem_done = Mem_Ready;
`else
   assign mem_done = 1'b1;
`endif
   always_ff @(posedge Clk) begin
      if (Reset) begin
         State       <= FETCH;
         Instr_Count <= '0;
      end else begin
         State       <= next_state;
         Instr_Count <= PC_LdEn ? Instr_Count + 1'b1 : Instr_Count;
      end
   end
   // Unused encodings 5-7 fall through to FETCH.
   always_comb begin
      next_state = State == FETCH  ? DECODE :
                   State == DECODE ? (legal ? EXEC : FETCH) :
                   State == EXEC   ? (is_br ? FETCH : (is_ld | is_st) ? MEM : WB) :
                   State == MEM    ? (!mem_done ? MEM : is_st ? FETCH : WB) :
                   FETCH;
   end
   // PC_LdEn marks the last cycle of each instruction; a stalled store waits for mem_done.
   always_comb begin
      PC_LdEn       = (State == DECODE && !legal) || (State == EXEC && is_br) ||
                      (State == MEM && is_st && mem_done) || State == WB;
      PC_sel        = State == EXEC && (is_b || (is_beq && ALU_Zero) || (is_bne && !ALU_Zero));
      RF_WrEn       = State == WB;
      RF_WrData_sel = State == WB && is_ld;
      MEM_WrEn      = State == MEM && is_st;
      RF_B_sel      = is_st | is_beq | is_bne;
      ALU_Bin_sel   = is_addi | is_andi | is_ori | is_li | is_lui | is_ld | is_st;
      ByteOp        = is_lb | is_sb;
      ALU_func      = is_r ? Instr[3:0] : is_andi ? 4'b0010 : is_ori ? 4'b0011 :
                      (is_beq | is_bne) ? 4'b0001 : 4'b0000;
   end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench; each test pushes per-cycle expected outputs, a negedge monitor pops and compares.
// Define CTRL_MEM_WAIT_EN to also exercise the Mem_Ready wait states.
module tb_control_fsm;
   localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4;
   logic        Clk = 1'b0, Reset = 1'b1, ALU_Zero = 1'b0;
   logic [31:0] Instr = '0;
`ifdef CTRL_MEM_WAIT_EN
   logic        Mem_Ready = 1'b1;
`endif
   logic        PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, MEM_WrEn, ByteOp;
   logic [3:0]  ALU_func;
   logic [2:0]  State;
   logic [2:0]  Instr_Count;
   logic [17:0] sb[$];
   logic [17:0] exp_v, got_v;
   logic [2:0]  cnt = '0, sel = '0;
   logic [3:0]  af = '0;
   int          vectors = 0, miscompares = 0;
   string       cur_name = "reset";

   control_fsm #(.COUNT_W(3)) dut (
      .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_Zero(ALU_Zero),
`ifdef CTRL_MEM_WAIT_EN
      .Mem_Ready(Mem_Ready),
`endif
      .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
      .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .MEM_WrEn(MEM_WrEn),
      .ByteOp(ByteOp), .State(State), .Instr_Count(Instr_Count));

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (sb.size() > 0) begin
         exp_v = sb.pop_front();
         got_v = {State, PC_LdEn, PC_sel, RF_WrEn, MEM_WrEn, RF_WrData_sel,
                  ByteOp, ALU_Bin_sel, RF_B_sel, ALU_func, Instr_Count};
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: state/ld/sel/rfwe/memwe/wdsel/byte/bin/bsel/func/cnt got %b expected %b",
                     cur_name, got_v, exp_v);
         end
      end
   end

   task automatic push(input logic [2:0] st, input logic pl, ps, rw, mw, ws);
      sb.push_back({st, pl, ps, rw, mw, ws, sel, af, cnt});
      if (pl) cnt = cnt + 3'd1;
   endtask

   task automatic issue(input string nm, input logic [5:0] op, input logic [3:0] fn, input logic z,
                        input logic [2:0] s, input logic [3:0] f);
      cur_name = nm;
      Instr    = {op, 22'($urandom), fn};
      ALU_Zero = z;
      sel      = s;
      af       = f;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() > 0 && k < 20) begin
         @(posedge Clk);
         k++;
      end
      if (sb.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: timeout with %0d entries pending, required 0", cur_name, sb.size());
         sb.delete();
      end
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge Clk);
      #1;
      vectors++;
      if ({State, Instr_Count, PC_LdEn, RF_WrEn, MEM_WrEn} !== 9'b0) begin
         miscompares++;
         $display("FAIL reset: state/cnt/ld/rfwe/memwe got %b required 0", {State, Instr_Count, PC_LdEn, RF_WrEn, MEM_WrEn});
      end
      Reset = 1'b0;
   endtask

   task automatic alu_op(input string nm, input logic [5:0] op, input logic [3:0] fn, input logic [2:0] s, input logic [3:0] f);
      issue(nm, op, fn, 1'($urandom), s, f);
      push(F, 0, 0, 0, 0, 0); push(D, 0, 0, 0, 0, 0); push(E, 0, 0, 0, 0, 0); push(W, 1, 0, 1, 0, 0);
      drain();
   endtask

   task automatic test_alu();
      alu_op("add", 6'b100000, 4'b0000, 3'b000, 4'b0000);
      vectors++;
      if (Instr_Count !== 3'd1) begin
         miscompares++;
         $display("FAIL add_count: got %0d required 1", Instr_Count);
      end
      alu_op("rtype_func6", 6'b100000, 4'b0110, 3'b000, 4'b0110);
      alu_op("addi", 6'b110000, 4'b1010, 3'b010, 4'b0000);
      alu_op("andi", 6'b110010, 4'b0101, 3'b010, 4'b0010);
      alu_op("ori",  6'b110011, 4'b1111, 3'b010, 4'b0011);
      alu_op("li",   6'b111000, 4'b0011, 3'b010, 4'b0000);
      alu_op("lui",  6'b111001, 4'b0001, 3'b010, 4'b0000);
   endtask

   task automatic branch(input string nm, input logic [5:0] op, input logic z, input logic taken, input logic [2:0] s, input logic [3:0] f);
      issue(nm, op, 4'($urandom), z, s, f);
      push(F, 0, 0, 0, 0, 0); push(D, 0, 0, 0, 0, 0); push(E, 1, taken, 0, 0, 0);
      drain();
   endtask

   task automatic test_branch();
      branch("beq_z1", 6'b000000, 1'b1, 1'b1, 3'b001, 4'b0001);
      branch("beq_z0", 6'b000000, 1'b0, 1'b0, 3'b001, 4'b0001);
      branch("bne_z1", 6'b000001, 1'b1, 1'b0, 3'b001, 4'b0001);
      branch("bne_z0", 6'b000001, 1'b0, 1'b1, 3'b001, 4'b0001);
      branch("b",      6'b111111, 1'b0, 1'b1, 3'b000, 4'b0000);
   endtask

   task automatic test_mem();
      issue("lw", 6'b001111, 4'($urandom), 1'($urandom), 3'b010, 4'b0000);
      push(F, 0, 0, 0, 0, 0); push(D, 0, 0, 0, 0, 0); push(E, 0, 0, 0, 0, 0); push(M, 0, 0, 0, 0, 0); push(W, 1, 0, 1, 0, 1);
      drain();
      issue("lb", 6'b000011, 4'($urandom), 1'($urandom), 3'b110, 4'b0000);
      push(F, 0, 0, 0, 0, 0); push(D, 0, 0, 0, 0, 0); push(E, 0, 0, 0, 0, 0); push(M, 0, 0, 0, 0, 0); push(W, 1, 0, 1, 0, 1);
      drain();
      issue("sb", 6'b000111, 4'($urandom), 1'($urandom), 3'b111, 4'b0000);
      push(F, 0, 0, 0, 0, 0); push(D, 0, 0, 0, 0, 0); push(E, 0, 0, 0, 0, 0); push(M, 1, 0, 0, 1, 0);
      drain();
      issue("sw", 6'b011111, 4'($urandom), 1'($urandom), 3'b011, 4'b0000);
      push(F, 0, 0, 0, 0, 0); push(D, 0, 0, 0, 0, 0); push(E, 0, 0, 0, 0, 0); push(M, 1, 0, 0, 1, 0);
      drain();
   endtask

   task automatic nop(input string nm);
      issue(nm, 6'b101010, 4'($urandom), 1'($urandom), 3'b000, 4'b0000);
      push(F, 0, 0, 0, 0, 0); push(D, 1, 0, 0, 0, 0);
      drain();
   endtask

   task automatic test_illegal();
      nop("illegal_101010");
      issue("illegal_010101", 6'b010101, 4'b0010, 1'b1, 3'b000, 4'b0000);
      push(F, 0, 0, 0, 0, 0); push(D, 1, 0, 0, 0, 0);
      drain();
   endtask

   task automatic test_reset_mid();
      issue("sw_reset_in_mem", 6'b011111, 4'($urandom), 1'($urandom), 3'b011, 4'b0000);
      push(F, 0, 0, 0, 0, 0); push(D, 0, 0, 0, 0, 0); push(E, 0, 0, 0, 0, 0); push(M, 1, 0, 0, 1, 0);
      cnt = '0;
      push(F, 0, 0, 0, 0, 0);
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b1;
      drain();
      vectors++;
      if ({State, Instr_Count, MEM_WrEn} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_mid: state/cnt/memwe got %b required 0", {State, Instr_Count, MEM_WrEn});
      end
      Reset = 1'b0;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 8 && cnt != 3'd7; i++) nop("wrap_fill");
      vectors++;
      if (Instr_Count !== 3'd7) begin
         miscompares++;
         $display("FAIL wrap_pre: got %0d required 7", Instr_Count);
      end
      nop("wrap");
      vectors++;
      if (Instr_Count !== 3'd0) begin
         miscompares++;
         $display("FAIL wrap_post: got %0d required 0", Instr_Count);
      end
   endtask

`ifdef CTRL_MEM_WAIT_EN
   task automatic test_mem_wait();
      for (int i = 0; i < 8 && cnt != 3'd7; i++) nop("wait_fill");
      issue("sw_wait", 6'b011111, 4'($urandom), 1'($urandom), 3'b011, 4'b0000);
      Mem_Ready = 1'b0;
      push(F, 0, 0, 0, 0, 0); push(D, 0, 0, 0, 0, 0); push(E, 0, 0, 0, 0, 0);
      push(M, 0, 0, 0, 1, 0); push(M, 0, 0, 0, 1, 0); push(M, 0, 0, 0, 1, 0); push(M, 1, 0, 0, 1, 0);
      push(F, 0, 0, 0, 0, 0);
      repeat (6) @(posedge Clk);
      #1 Mem_Ready = 1'b1;
      drain();
      vectors++;
      if (Instr_Count !== 3'd0) begin
         miscompares++;
         $display("FAIL wait_wrap: got %0d required 0", Instr_Count);
      end
   endtask
`endif

   task automatic test_back_to_back();
      alu_op("b2b_add", 6'b100000, 4'b1001, 3'b000, 4'b1001);
      branch("b2b_b", 6'b111111, 1'b1, 1'b1, 3'b000, 4'b0000);
      nop("b2b_nop");
      alu_op("b2b_ori", 6'b110011, 4'b0000, 3'b010, 4'b0011);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_mem();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
`ifdef CTRL_MEM_WAIT_EN
      test_mem_wait();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
